spin_readout: RTL and testbench
===============================

# spin_readout

Reads out the Ising solution from the oscillator array's `outputs_ver` bus. For each oscillator it counts, over a fixed sampling window, the cycles whose value disagrees with oscillator 0 (the phase reference). A majority vote on that count gives one spin bit per oscillator. The block sits between the free-running core matrix and the host control logic, and returns the spin vector through a valid/ready handshake.

## Interface
Parameters:
- `N`, 3: number of oscillators; must match the core matrix.
- `WINDOW`, 1024: sampling cycles per readout; must be even and ≥ 2.
- `SETTLE_CYCLES`, 16: cycles discarded after `start`, before sampling begins; ≥ 1.
- `CW`, `$clog2(WINDOW+1)`: width of each count field; derived.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `osc_in`  in  N: oscillator outputs, asynchronous to `clk`.
- `start`  in  1: one-cycle request to begin a readout.
- `busy`  out  1: high in SETTLE and SAMPLE.
- `valid`  out  1: result available.
- `ready`  in  1: consumer accepts the result.
- `spins`  out  N: bit i = 1 means oscillator i is anti-phase with oscillator 0.
- `counts`  out  N*CW: disagreement count for oscillator i at `counts[i*CW +: CW]`.

## Operation
- `osc_in` passes through a 2-flop synchronizer per bit, giving `s[N-1:0]`. Synchronizer flops reset to 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
  - IDLE: `start` = 1 → SETTLE. Clear all counts, `spins`, and the cycle counter.
  - SETTLE: run `SETTLE_CYCLES` cycles → SAMPLE.
  - SAMPLE: run `WINDOW` cycles. Each cycle, for i ≥ 1, if `s[i] != s[0]` then `cnt[i]++`. `cnt[0]` stays 0.
  - After the last SAMPLE cycle, register `spins[i] = (cnt[i] > WINDOW/2)` and go to DONE. A tie (exactly `WINDOW/2`) gives 0. `spins[0]` is always 0.
  - DONE: `valid` = 1. When `valid & ready` → IDLE.
- `start` is ignored in every state except IDLE, including the handshake cycle in DONE.
- Counts cannot overflow: maximum value is `WINDOW`, and `CW` holds it.
- `spins` and `counts` hold their values after the handshake. They are cleared only when the next `start` is accepted.
- `rst` in any state: IDLE next cycle, with all counters, outputs, and synchronizer flops cleared. A readout in progress is discarded.

## Timing
- Reset value of every output is 0: `busy`, `valid`, `spins`, `counts`.
- Take `start` sampled in IDLE at edge t:
  - `busy` = 1 from t+1 through t+SETTLE_CYCLES+WINDOW.
  - `valid` = 1 from t+1+SETTLE_CYCLES+WINDOW.
  - Total latency from `start` to `valid` is 1+SETTLE_CYCLES+WINDOW cycles.
- `valid` stays high and data stays stable until the cycle in which `ready` = 1. `valid` = 0 the following cycle.
- If `ready` is already high when `valid` rises, the handshake completes in one cycle.
- Synchronizer delay is 2 cycles. Sampled data lags `osc_in` by 2 cycles. `SETTLE_CYCLES` ≥ 2 absorbs this.
- `counts` updates during SAMPLE; it is meaningful only while `valid` = 1.

## Structure
- Shared header `spin_readout_defs.vh`:
  - state encoding localparams (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3), 2 bits;
  - the `CW` derivation macro.
- Sub-module `sync2`: parameterized-width two-flop synchronizer with synchronous active-high reset. Instantiate it once with width `N`.
- Cycle counter width: `$clog2(max(WINDOW, SETTLE_CYCLES)+1)`. It is shared between SETTLE and SAMPLE and reloaded on each transition.

## Test plan
All tests use N=3, WINDOW=16, SETTLE_CYCLES=4.
- **Reset:** hold `rst` 3 cycles, then release → `busy`=0, `valid`=0, `spins`=0, `counts`=0. `start` pulse → `valid` exactly 21 cycles later.
- **All in phase:** `osc_in` toggles 000/111 every 3 cycles → `counts` = {0,0,0}, `spins` = 3'b000.
- **Anti-phase:** `osc_in[2]` = ~`osc_in[0]`, `osc_in[1]` = `osc_in[0]` → `cnt2`=16, `cnt1`=0, `spins`=3'b100.
- **Tie boundary:**
  - `osc_in[1]` disagrees on exactly 8 of 16 sampled cycles → `cnt1`=8, `spins[1]`=0.
  - Repeat with 9 disagreeing cycles → `cnt1`=9, `spins[1]`=1.
- **Backpressure:** hold `ready`=0 for 10 cycles after `valid`, and pulse `start` during that time → `valid` and data held, `start` ignored. Raise `ready` → `valid`=0 next cycle, state IDLE, `busy`=0.
- **Reset mid-operation:** assert `rst` at SAMPLE cycle 7 → next cycle `busy`=0, `counts`=0. A new `start` completes normally with `valid` after 21 cycles.

Source files
------------

// File: rtl/spin_readout_pkg.sv
// rtl/spin_readout_pkg.sv - shared state encoding and width helpers for spin_readout
package spin_readout_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int count_width(input int window);
    return $clog2(window + 1);
  endfunction

  // One down-counter serves both SETTLE and SAMPLE, so size it for the longer phase.
  function automatic int cycle_width(input int window, input int settle);
    return $clog2(((window > settle) ? window : settle) + 1);
  endfunction

endpackage

// File: rtl/spin_readout_sync2.sv
// rtl/spin_readout_sync2.sv - parameterized two-flop synchronizer, synchronous active-high reset
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spin_readout.sv
// rtl/spin_readout.sv - majority-vote spin readout of the oscillator array against oscillator 0
module spin_readout
  import spin_readout_pkg::*;
#(
  parameter int N             = 3,
  parameter int WINDOW        = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int CW            = count_width(WINDOW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    osc_in,
  input  logic            start,
  output logic            busy,
  output logic            valid,
  input  logic            ready,
  output logic [N-1:0]    spins,
  output logic [N*CW-1:0] counts
);

  localparam int TW = cycle_width(WINDOW, SETTLE_CYCLES);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] WINDOW_LAST = TW'(WINDOW - 1);
  localparam logic [CW-1:0] HALF        = CW'(WINDOW / 2);

  logic [N-1:0]  s;
  state_t        state;
  logic [TW-1:0] cyc;
  logic [CW-1:0] cnt      [N];
  logic [CW-1:0] cnt_next [N];

  sync2 #(.W(N)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (osc_in),
    .q   (s)
  );

  // Oscillator 0 is the phase reference, so its own count never moves.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_next[i] = cnt[i];
      if (i != 0 && s[i] != s[0]) cnt_next[i] = cnt[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cyc   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
      spins <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SETTLE;
            busy  <= 1'b1;
            cyc   <= SETTLE_LAST;
            spins <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
          end
        end
        SETTLE: begin
          if (cyc == '0) begin
            state <= SAMPLE;
            cyc   <= WINDOW_LAST;
          end else begin
            cyc <= cyc - 1'b1;
          end
        end
        SAMPLE: begin
          cnt <= cnt_next;
          if (cyc == '0) begin
            // Vote on the counts including this final sample; a tie votes 0.
            for (int i = 0; i < N; i++) spins[i] <= (cnt_next[i] > HALF);
            state <= DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
          end else begin
            cyc <= cyc - 1'b1;
          end
        end
        DONE: begin
          if (ready) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_counts
    assign counts[g*CW +: CW] = cnt[g];
  end

endmodule

// File: tb/tb_spin_readout.sv
// tb/tb_spin_readout.sv - scoreboard bench for spin_readout (N=3, WINDOW=16, SETTLE_CYCLES=4)
module tb_spin_readout;

  localparam int N      = 3;
  localparam int WINDOW = 16;
  localparam int SETTLE = 4;
  localparam int CW     = 5;
  localparam int LAT    = SETTLE + WINDOW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    osc_in;
  logic            start;
  logic            busy;
  logic            valid;
  logic            ready;
  logic [N-1:0]    spins;
  logic [N*CW-1:0] counts;

  typedef struct packed {
    logic [N-1:0]    spins;
    logic [N*CW-1:0] counts;
  } result_t;

  result_t      exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] hist [0:LAT];

  always #5 clk = ~clk;

  spin_readout #(
    .N             (N),
    .WINDOW        (WINDOW),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .osc_in (osc_in),
    .start  (start),
    .busy   (busy),
    .valid  (valid),
    .ready  (ready),
    .spins  (spins),
    .counts (counts)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] gen(input int mode, input int c, input int k);
    logic b0;
    case (mode)
      0: return (((c / 3) % 2) == 1) ? 3'b111 : 3'b000;
      1: begin
        b0 = (((c / 2) % 2) == 1);
        return {~b0, b0, b0};
      end
      2: begin
        b0 = (((c / 4) % 2) == 1);
        return {b0, b0 ^ (c >= SETTLE - 1 && c < SETTLE - 1 + k), b0};
      end
      default: return N'($urandom_range(0, 7));
    endcase
  endfunction

  // Osc value driven before edge c is seen by the counter at edge c+2; sampling edges are SETTLE+1..LAT.
  function automatic result_t model(input int last);
    result_t r;
    int n;
    r = '0;
    for (int i = 1; i < N; i++) begin
      n = 0;
      for (int c = SETTLE - 1; c <= last; c++)
        if (hist[c][i] != hist[c][0]) n++;
      r.counts[i*CW +: CW] = CW'(n);
      r.spins[i] = (n > WINDOW / 2);
    end
    return r;
  endfunction

  task automatic run_readout(input int mode, input int k, input int hold);
    result_t e;
    for (int c = 0; c <= LAT; c++) hist[c] = gen(mode, c, k);
    exp_q.push_back(model(LAT - 2));
    ready = (hold == 0);
    for (int c = 0; c <= LAT; c++) begin
      osc_in = hist[c];
      start  = (c == 0);
      tick();
      start = 1'b0;
      check($sformatf("busy@%0d", c), busy, c < LAT);
      check($sformatf("valid@%0d", c), valid, c >= LAT);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("spins", spins, e.spins);
      check("counts", counts, e.counts);
      if (hold == 0) begin
        tick();
        check("valid_one_cycle", valid, 0);
        check("busy_after_hs", busy, 0);
      end else begin
        for (int j = 0; j < hold; j++) begin
          start = (j == 3);
          tick();
          start = 1'b0;
          check("valid_held", valid, 1);
          check("busy_in_done", busy, 0);
          check("spins_held", spins, e.spins);
          check("counts_held", counts, e.counts);
        end
        ready = 1'b1;
        start = 1'b1;
        tick();
        ready = 1'b0;
        start = 1'b0;
        check("valid_after_hs", valid, 0);
        check("busy_after_hs", busy, 0);
        tick();
        check("busy_idle", busy, 0);
        check("spins_after_hs", spins, e.spins);
        check("counts_after_hs", counts, e.counts);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    ready  = 1'b0;
    osc_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_spins", spins, 0);
    check("rst_counts", counts, 0);

    run_readout(0, 0, 0);
    run_readout(1, 0, 2);
    run_readout(2, 8, 1);
    run_readout(2, 9, 1);
    run_readout(3, 0, 10);

    // Abort in the seventh SAMPLE cycle with an anti-phase input.
    for (int c = 0; c <= LAT; c++) hist[c] = gen(1, c, 0);
    for (int c = 0; c <= SETTLE + 7; c++) begin
      osc_in = hist[c];
      start  = (c == 0);
      tick();
      start = 1'b0;
    end
    check("partial_counts", counts, model(SETTLE + 5).counts);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_counts", counts, 0);
    check("abort_spins", spins, 0);

    run_readout(1, 0, 0);
    run_readout(3, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
